// File: rtl/i2c_pkg.sv
// i2c_pkg: command codes, sequencer phases and the per-phase {SclOe,SdaOe} patterns
// shared by the bit sequencer and the byte controller.
package i2c_pkg;

    typedef enum logic [1:0] {I2C_START, I2C_STOP, I2C_WRITE, I2C_READ} cmd_t;
    typedef enum logic [2:0] {IDLE, PA, PB, PC, PD} phase_t;

    // {SclOe,SdaOe} pairs for PA,PB,PC,PD with PA in the top bits
    localparam logic [7:0] START_LINES = 8'b00_00_01_11;
    localparam logic [7:0] STOP_LINES  = 8'b11_01_01_00;
    localparam logic [7:0] READ_LINES  = 8'b10_00_00_10;
    localparam logic [3:0] WRITE_SCL   = 4'b1001;

    // Quarter count at which the 2-flop SCL synchroniser has seen the PB release
    localparam int STRETCH_CHECK = 2;

    function automatic logic [1:0] phase_lines(cmd_t c, phase_t p, logic b);
        logic [7:0] t;
        int i;
        t = c == I2C_START ? START_LINES :
            c == I2C_STOP  ? STOP_LINES  :
            c == I2C_READ  ? READ_LINES  :
            {WRITE_SCL[3], ~b, WRITE_SCL[2], ~b, WRITE_SCL[1], ~b, WRITE_SCL[0], ~b};
        i = int'(p) - int'(PA);
        return t[6 - 2 * i +: 2];
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: quarter-bit-period counter; Tick flags the last cycle of a quarter.
module i2c_quarter_tick #(
    parameter int QDIV = 250,
    parameter int QW   = $clog2(QDIV)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Clear,
    input  logic          Hold,
    output logic          Tick,
    output logic [QW-1:0] Count
);

    assign Tick = Count == QW'(QDIV - 1) && !Hold;

    always_ff @(posedge Clk or negedge Reset)
        if (!Reset)
            Count <= '0;
        else if (Clear || Tick)
            Count <= '0;
        else if (!Hold)
            Count <= Count + QW'(1);

endmodule

// File: rtl/i2c_bit_sequencer.sv
// i2c_bit_sequencer: runs one START/STOP/WRITE/READ bit command as four quarter-period
// phases on open-drain SCL/SDA, with SCL clock stretching and RX bit sampling.
module i2c_bit_sequencer
    import i2c_pkg::*;
#(
    parameter int INPUT_CLK = 100_000_000,
    parameter int BUS_CLK   = 100_000,
    parameter int QDIV      = INPUT_CLK / (4 * BUS_CLK),
    parameter int QW        = $clog2(QDIV)
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       CmdValid,
    output logic       CmdReady,
    input  logic [1:0] Cmd,
    input  logic       TxBit,
    output logic       Done,
    output logic       RxBit,
    output logic       RxValid,
    output logic       Busy,
    output logic       SclOe,
    output logic       SdaOe,
    input  logic       SclIn,
    input  logic       SdaIn
);

    localparam int HOLD_AT = QDIV - 1 < STRETCH_CHECK ? QDIV - 1 : STRETCH_CHECK;

    phase_t        state, next;
    cmd_t          cmd_q;
    logic          tx_q, scl_oe, sda_oe, done_q, rx_valid, rx_bit;
    logic [1:0]    scl_sync, sda_sync;
    logic [QW-1:0] count;
    logic          tick, hold;

    // Stretch is judged once the synchroniser reflects the released SCL, so an
    // unstretched PB keeps its nominal length.
    assign hold = state == PB && !scl_sync[1] && count == QW'(HOLD_AT);
    assign next = state == PD ? IDLE : phase_t'(state + 3'd1);

    i2c_quarter_tick #(.QDIV(QDIV), .QW(QW)) u_tick (
        .Clk  (Clk),
        .Reset(Reset),
        .Clear(state == IDLE),
        .Hold (hold),
        .Tick (tick),
        .Count(count)
    );

    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], SclIn};
            sda_sync <= {sda_sync[0], SdaIn};
        end

    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            state    <= IDLE;
            cmd_q    <= I2C_START;
            tx_q     <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            done_q   <= 1'b0;
            rx_valid <= 1'b0;
            rx_bit   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rx_valid <= 1'b0;
            if (state == IDLE) begin
                if (CmdValid) begin
                    state            <= PA;
                    cmd_q            <= cmd_t'(Cmd);
                    tx_q             <= TxBit;
                    {scl_oe, sda_oe} <= phase_lines(cmd_t'(Cmd), PA, TxBit);
                end
            end else if (tick) begin
                state <= next;
                if (state == PD) begin
                    done_q   <= 1'b1;
                    rx_valid <= cmd_q == I2C_READ;
                end else
                    {scl_oe, sda_oe} <= phase_lines(cmd_q, next, tx_q);
                if (state == PC && cmd_q == I2C_READ)
                    rx_bit <= sda_sync[1];
            end
        end

    assign CmdReady = state == IDLE;
    assign Busy     = !CmdReady;
    assign Done     = done_q;
    assign RxValid  = rx_valid;
    assign RxBit    = rx_bit;
    assign SclOe    = scl_oe;
    assign SdaOe    = sda_oe;

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// tb_i2c_bit_sequencer: directed bench with a cycle-count reference model of the
// bit sequencer and open-drain pull-up pads.
module tb_i2c_bit_sequencer;

    localparam int QDIV = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic       tx_bit = 1'b0;
    logic       slave_scl_low = 1'b0;
    logic       slave_sda_low = 1'b0;
    logic       lax = 1'b0;
    logic       cmd_ready, done, rx_bit, rx_valid, busy, scl_oe, sda_oe;
    wire        scl_pad = ~scl_oe & ~slave_scl_low;
    wire        sda_pad = ~sda_oe & ~slave_sda_low;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_t[$];

    i2c_bit_sequencer #(.INPUT_CLK(400), .BUS_CLK(10)) dut (
        .Clk     (clk),
        .Reset   (rst_n),
        .CmdValid(cmd_valid),
        .CmdReady(cmd_ready),
        .Cmd     (cmd),
        .TxBit   (tx_bit),
        .Done    (done),
        .RxBit   (rx_bit),
        .RxValid (rx_valid),
        .Busy    (busy),
        .SclOe   (scl_oe),
        .SdaOe   (sda_oe),
        .SclIn   (scl_pad),
        .SdaIn   (sda_pad)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line pattern {SclOe,SdaOe} of quarter ph (0..3) straight from the waveform table
    function automatic logic [1:0] exp_lines(logic [1:0] c, int ph, logic b);
        case (c)
            2'd0:    return ph <= 1 ? 2'b00 : ph == 2 ? 2'b01 : 2'b11;
            2'd1:    return ph == 0 ? 2'b11 : ph == 3 ? 2'b00 : 2'b01;
            2'd2:    return {ph == 0 || ph == 3, ~b};
            default: return {ph == 0 || ph == 3, 1'b0};
        endcase
    endfunction

    // Reference model: m_t counts cycles since the accept edge; a command is busy for
    // 4*QDIV cycles and completes in cycle 4*QDIV, where a new accept may occur.
    logic       m_active = 1'b0;
    int         m_t = 0;
    int         m_accepts = 0;
    logic [1:0] m_cmd = 2'd0;
    logic       m_b = 1'b0;
    logic [1:0] m_idle = 2'b00;
    logic       m_rx = 1'b0;
    wire        m_ready = !m_active || m_t >= 4 * QDIV;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_idle   <= 2'b00;
            m_rx     <= 1'b0;
        end else begin
            if (m_ready && cmd_valid) begin
                m_active  <= 1'b1;
                m_t       <= 0;
                m_cmd     <= cmd;
                m_b       <= tx_bit;
                m_idle    <= exp_lines(cmd, 3, tx_bit);
                m_accepts <= m_accepts + 1;
            end else if (m_active && m_t <= 4 * QDIV)
                m_t <= m_t + 1;
            if (m_active && m_cmd == 2'd3 && m_t == 3 * QDIV - 1)
                m_rx <= sda_pad;
        end

    always @(negedge clk)
        if (!lax) begin
            logic       busy_e;
            logic [1:0] lines_e;
            busy_e  = m_active && m_t < 4 * QDIV;
            lines_e = busy_e ? exp_lines(m_cmd, m_t / QDIV, m_b) : m_idle;
            chk1("cmd_ready", cmd_ready, !busy_e);
            chk1("busy", busy, busy_e);
            chk1("done", done, m_active && m_t == 4 * QDIV);
            chk1("rx_valid", rx_valid, m_active && m_t == 4 * QDIV && m_cmd == 2'd3);
            chk1("scl_oe", scl_oe, lines_e[1]);
            chk1("sda_oe", sda_oe, lines_e[0]);
            chk1("rx_bit", rx_bit, m_rx);
        end

    always @(negedge clk)
        if (done) done_t.push_back(cyc);

    task automatic send(input logic [1:0] c, input logic b);
        int k;
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: cmd_ready stayed 0 for %0d cycles", k);
        end
        cmd_valid = 1'b1;
        cmd       = c;
        tx_bit    = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = 2'($urandom);
        tx_bit    = 1'($urandom);
    endtask

    // Observes the command from the first sample after the accept edge (n=1) until Done
    task automatic trace(output int n_done, output int sda_hi, output int scl_lo,
                         output int first_sda, output int first_scl);
        n_done = 0; sda_hi = 0; scl_lo = 0; first_sda = 0; first_scl = 0;
        for (int n = 1; n <= 200 && n_done == 0; n++) begin
            if (n <= 4 * QDIV) begin
                sda_hi += int'(sda_oe);
                scl_lo += int'(!scl_oe);
            end
            if (sda_oe && first_sda == 0) first_sda = n;
            if (scl_oe && first_scl == 0) first_scl = n;
            if (done) n_done = n;
            else @(negedge clk);
        end
        if (n_done == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no Done within 200 cycles");
        end
    endtask

    initial begin
        int nd, sh, sl, fs, fc, k, base;
        logic [1:0] seq [4];
        seq = '{2'd0, 2'd2, 2'd3, 2'd1};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk1("reset_scl_oe", scl_oe, 1'b0);
        chk1("reset_sda_oe", sda_oe, 1'b0);
        chk1("reset_cmd_ready", cmd_ready, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(2'd0, 1'b0);
        trace(nd, sh, sl, fs, fc);
        chk("start_sda_rise", fs, 21);
        chk("start_scl_rise", fc, 31);
        chk("start_done", nd, 41);
        @(negedge clk);

        send(2'd2, 1'b0);
        trace(nd, sh, sl, fs, fc);
        chk("write0_sda_cycles", sh, 40);
        chk("write0_scl_low_cycles", sl, 20);
        chk("write0_done", nd, 41);
        @(negedge clk);

        slave_sda_low = 1'b1;
        send(2'd3, 1'b0);
        trace(nd, sh, sl, fs, fc);
        chk("read0_done", nd, 41);
        chk1("read0_rx_valid", rx_valid, 1'b1);
        chk1("read0_rx_bit", rx_bit, 1'b0);
        @(negedge clk);
        chk1("read0_rx_valid_end", rx_valid, 1'b0);
        slave_sda_low = 1'b0;

        send(2'd3, 1'b1);
        trace(nd, sh, sl, fs, fc);
        chk1("read1_rx_valid", rx_valid, 1'b1);
        chk1("read1_rx_bit", rx_bit, 1'b1);
        @(negedge clk);

        lax = 1'b1;
        slave_sda_low = 1'b1;
        send(2'd3, 1'b0);
        nd = 0;
        for (int n = 1; n <= 300 && nd == 0; n++) begin
            if (n == 11) slave_scl_low = 1'b1;
            if (n == 36) slave_scl_low = 1'b0;
            if (done) nd = n;
            else @(negedge clk);
        end
        chk("stretch_done", nd, nd == 67 ? 67 : 66);
        chk1("stretch_rx_bit", rx_bit, 1'b0);
        chk1("stretch_rx_valid", rx_valid, 1'b1);
        @(negedge clk);
        lax = 1'b0;
        slave_sda_low = 1'b0;
        @(negedge clk);

        done_t.delete();
        base = m_accepts;
        cmd_valid = 1'b1;
        tx_bit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd = seq[i];
            k = 0;
            while (m_accepts == base + i && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        cmd_valid = 1'b0;
        k = 0;
        while (done_t.size() < 4 && k < 300) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("b2b_done_count", done_t.size(), 4);
        for (int i = 1; i < 4 && i < done_t.size(); i++)
            chk("b2b_spacing", done_t[i] - done_t[i-1], 41);
        chk1("b2b_final_scl_oe", scl_oe, 1'b0);
        chk1("b2b_final_sda_oe", sda_oe, 1'b0);

        send(2'd2, 1'b0);
        repeat (24) @(negedge clk);
        chk1("midpc_sda_oe", sda_oe, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_reset_scl_oe", scl_oe, 1'b0);
        chk1("async_reset_sda_oe", sda_oe, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            k += int'(done);
        end
        chk("abort_no_done", k, 0);
        chk1("abort_cmd_ready", cmd_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
